// File: rtl/fetch_unit.sv
// Instruction fetch front end: it walks the PC, issues requests to instruction memory and
// registers the returned word for decode. It handles stalls from downstream and branch redirects.
module fetch_unit #(
  parameter int                      ADDRESS_BITS = 32,
  parameter logic [ADDRESS_BITS-1:0] RESET_PC     = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    branch,
  input  logic [ADDRESS_BITS-1:0] target_PC,
  input  logic                    imem_ready,
  input  logic [31:0]             imem_rdata,
  output logic                    imem_req,
  output logic [ADDRESS_BITS-1:0] imem_addr,
  output logic [31:0]             instruction,
  output logic [ADDRESS_BITS-1:0] inst_PC,
  output logic                    inst_valid
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] FETCH   = 2'd1;
  localparam logic [1:0] STALLED = 2'd2;

  // Instructions are word aligned, so the two low address bits are always cleared.
  function automatic logic [ADDRESS_BITS-1:0] word_align(input logic [ADDRESS_BITS-1:0] a);
    return a & ~ADDRESS_BITS'(3);
  endfunction

  localparam logic [ADDRESS_BITS-1:0] PC_INIT = RESET_PC & ~ADDRESS_BITS'(3);

  logic [1:0]              state, state_nxt;
  logic [ADDRESS_BITS-1:0] pc, pc_nxt;
  logic [31:0]             instruction_nxt;
  logic [ADDRESS_BITS-1:0] inst_pc_nxt;
  logic                    inst_valid_nxt;

  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    instruction_nxt = instruction;
    inst_pc_nxt     = inst_PC;
    inst_valid_nxt  = inst_valid;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        // A redirect wins over both stall and imem_ready, and drops any word that arrives in the same cycle.
        if (branch) begin
          pc_nxt         = word_align(target_PC);
          inst_valid_nxt = 1'b0;
          state_nxt      = FETCH;
        end else if (imem_ready) begin
          instruction_nxt = imem_rdata;
          inst_pc_nxt     = pc;
          inst_valid_nxt  = 1'b1;
          pc_nxt          = pc + ADDRESS_BITS'(4);
          state_nxt       = stall ? STALLED : FETCH;
        end else if (inst_valid && stall) begin
          state_nxt = STALLED;
        end else begin
          inst_valid_nxt = 1'b0;
        end
      end
      STALLED: begin
        if (branch) begin
          pc_nxt         = word_align(target_PC);
          inst_valid_nxt = 1'b0;
          state_nxt      = FETCH;
        end else if (!stall) begin
          inst_valid_nxt = 1'b0;
          state_nxt      = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= PC_INIT;
      instruction <= '0;
      inst_PC     <= '0;
      inst_valid  <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      instruction <= instruction_nxt;
      inst_PC     <= inst_pc_nxt;
      inst_valid  <= inst_valid_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed stimulus pushes the instructions it expects into a queue,
// and a monitor pops and compares each new instruction that decode would see.
module tb_fetch_unit;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall, branch, imem_ready;
  logic [31:0] target_PC, imem_rdata;
  logic        imem_req, inst_valid;
  logic [31:0] imem_addr, instruction, inst_PC;

  // Second instance: unaligned reset PC at the top of the address space, used for the wrap case.
  logic        ready2;
  logic        stall2 = 1'b0, branch2 = 1'b0;
  logic [31:0] target2 = '0, rdata2;
  logic        req2, valid2;
  logic [31:0] addr2, ins2, ipc2;

  always #5 clock = ~clock;

  assign imem_rdata = imem_addr + 32'd100;
  assign rdata2     = 32'hDEAD0000;

  fetch_unit #(.ADDRESS_BITS(32), .RESET_PC(32'h00000000)) dut (
    .clock(clock), .reset(reset), .stall(stall), .branch(branch), .target_PC(target_PC),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .imem_req(imem_req),
    .imem_addr(imem_addr), .instruction(instruction), .inst_PC(inst_PC), .inst_valid(inst_valid)
  );

  fetch_unit #(.ADDRESS_BITS(32), .RESET_PC(32'hFFFFFFFE)) dut_wrap (
    .clock(clock), .reset(reset), .stall(stall2), .branch(branch2), .target_PC(target2),
    .imem_ready(ready2), .imem_rdata(rdata2), .imem_req(req2),
    .imem_addr(addr2), .instruction(ins2), .inst_PC(ipc2), .inst_valid(valid2)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t q[$];
  int   tests  = 0;
  int   failed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic push(input logic [31:0] pc);
    q.push_back('{pc, pc + 32'd100});
  endtask

  // Monitor: a new instruction is one that just became valid or differs from last cycle's.
  logic        prev_v   = 1'b0;
  logic [31:0] prev_pc  = '0;
  logic [31:0] prev_ins = '0;
  always @(negedge clock) begin
    if (inst_valid && (!prev_v || inst_PC != prev_pc || instruction != prev_ins)) begin
      if (q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_instr: got pc %h ins %h, expected none", inst_PC, instruction);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("mon_inst_PC", inst_PC, e.pc);
        chk("mon_instruction", instruction, e.ins);
      end
    end
    prev_v   = inst_valid;
    prev_pc  = inst_PC;
    prev_ins = instruction;
  end

  initial begin
    stall = 1'b0; branch = 1'b0; imem_ready = 1'b0; target_PC = '0; ready2 = 1'b0;
    repeat (2) step();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_instruction", instruction, 32'd0);
    chk("rst_inst_PC", inst_PC, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_addr_wrap", addr2, 32'hFFFFFFFC);

    // Release with branch high: IDLE ignores it.
    branch = 1'b1; target_PC = 32'h200; reset = 1'b1;
    step();
    branch = 1'b0;
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'd0);
    chk("first_req_wrap", 32'(req2), 32'd1);
    chk("first_addr_wrap", addr2, 32'hFFFFFFFC);

    ready2 = 1'b1;
    step();
    ready2 = 1'b0;
    chk("wrap_addr", addr2, 32'h00000000);
    chk("wrap_inst_PC", ipc2, 32'hFFFFFFFC);
    chk("wrap_instruction", ins2, 32'hDEAD0000);
    chk("wrap_valid", 32'(valid2), 32'd1);

    // Streaming
    imem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(32'(4 * i));
      step();
      chk("stream_valid", 32'(inst_valid), 32'd1);
      chk("stream_addr", imem_addr, 32'(4 * (i + 1)));
    end
    imem_ready = 1'b0;
    step();
    chk("noready_valid_drop", 32'(inst_valid), 32'd0);
    chk("noready_pc_hold", imem_addr, 32'd16);

    // Stall
    reset = 1'b0; step(); reset = 1'b1; step();
    chk("stall_start_addr", imem_addr, 32'd0);
    imem_ready = 1'b1;
    push(32'd0); step();
    push(32'd4); step();
    imem_ready = 1'b0; stall = 1'b1;
    step();
    chk("stall_req", 32'(imem_req), 32'd0);
    chk("stall_inst_PC", inst_PC, 32'd4);
    chk("stall_instruction", instruction, 32'd104);
    chk("stall_valid", 32'(inst_valid), 32'd1);
    chk("stall_pc", imem_addr, 32'd8);
    imem_ready = 1'b1;
    step();
    chk("stall_req2", 32'(imem_req), 32'd0);
    chk("stall_pc2", imem_addr, 32'd8);
    chk("stall_inst_PC2", inst_PC, 32'd4);
    step();
    stall = 1'b0; imem_ready = 1'b0;
    chk("stall_req3", 32'(imem_req), 32'd0);
    step();
    chk("unstall_req", 32'(imem_req), 32'd1);
    chk("unstall_addr", imem_addr, 32'd8);
    chk("unstall_valid", 32'(inst_valid), 32'd0);
    imem_ready = 1'b1;
    push(32'd8); step();

    // Redirect together with imem_ready: the word for address 12 is discarded.
    branch = 1'b1; target_PC = 32'h83;
    step();
    branch = 1'b0; imem_ready = 1'b0;
    chk("redir_rdy_addr", imem_addr, 32'h80);
    chk("redir_rdy_valid", 32'(inst_valid), 32'd0);
    chk("redir_rdy_req", 32'(imem_req), 32'd1);

    // Redirect while waiting, then a late imem_ready.
    branch = 1'b1; target_PC = 32'h43;
    step();
    branch = 1'b0; imem_ready = 1'b1;
    chk("redir_addr", imem_addr, 32'h40);
    chk("redir_valid", 32'(inst_valid), 32'd0);
    push(32'h40);
    step();
    imem_ready = 1'b0;
    chk("redir_next_addr", imem_addr, 32'h44);

    // Redirect from STALLED
    stall = 1'b1;
    step();
    chk("stalled_req", 32'(imem_req), 32'd0);
    branch = 1'b1; target_PC = 32'h100;
    step();
    branch = 1'b0; stall = 1'b0;
    chk("stalled_redir_valid", 32'(inst_valid), 32'd0);
    chk("stalled_redir_req", 32'(imem_req), 32'd1);
    chk("stalled_redir_addr", imem_addr, 32'h100);

    // Asynchronous reset pulse while STALLED, between clock edges
    imem_ready = 1'b1;
    push(32'h100);
    step();
    imem_ready = 1'b0; stall = 1'b1;
    step();
    chk("pre_areset_req", 32'(imem_req), 32'd0);
    chk("pre_areset_inst_PC", inst_PC, 32'h100);
    #2 reset = 1'b0;
    #1;
    chk("areset_valid", 32'(inst_valid), 32'd0);
    chk("areset_instruction", instruction, 32'd0);
    chk("areset_inst_PC", inst_PC, 32'd0);
    chk("areset_req", 32'(imem_req), 32'd0);
    chk("areset_addr", imem_addr, 32'd0);
    stall = 1'b0;
    #1 reset = 1'b1;
    step();
    chk("refetch_req", 32'(imem_req), 32'd1);
    chk("refetch_addr", imem_addr, 32'd0);
    step();
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
